spi_xfer_seq: RTL and testbench

Multi-byte transfer sequencer directly upstream of the single-byte SPI core. Accepts a transfer descriptor (byte count) plus TX/RX byte streams from the host side. Drives the core's cs/wr/rd/din strobes once per byte, collects each received byte from core dout, and frames the whole transaction with an external active-low slave select held across all bytes.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_ss_timer.sv | 30 +++
 rtl/spi_xfer_seq.sv | 149 ++++++++++++++
 tb/tb_spi_xfer_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared defaults and sequencer state encoding for the SPI transfer sequencer
package spi_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int LEN_W_DEF  = 8;
  localparam int SS_DLY_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SS_SETUP,
    ST_LOAD,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_READ,
    ST_CAPTURE,
    ST_RX_PUSH,
    ST_SS_HOLD,
    ST_DONE
  } xfer_state_t;

endpackage

// File: rtl/spi_ss_timer.sv
// rtl/spi_ss_timer.sv - slave-select guard timer; expires SS_DLY cycles after a load
module spi_ss_timer
  import spi_pkg::*;
#(
  parameter int SS_DLY = SS_DLY_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int CW = (SS_DLY > 1) ? $clog2(SS_DLY) : 1;

  logic [CW-1:0] r_cnt;

  // Loaded with SS_DLY-1 so the owning state lasts exactly SS_DLY cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(SS_DLY - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// rtl/spi_xfer_seq.sv - multi-byte transfer sequencer framing single-byte SPI core transfers
module spi_xfer_seq
  import spi_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int SS_DLY = SS_DLY_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_abort,
  input  logic [DWIDTH-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DWIDTH-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic              o_ss_n,
  output logic              o_core_cs,
  output logic              o_core_wr,
  output logic              o_core_rd,
  output logic [DWIDTH-1:0] o_core_din,
  input  logic [DWIDTH-1:0] i_core_dout,
  input  logic              i_core_busy
);

  xfer_state_t       r_state;
  xfer_state_t       w_next;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_ss_n;
  logic              r_core_wr;
  logic              r_aborted;
  logic              r_rx_valid;
  logic [DWIDTH-1:0] r_core_din;
  logic [DWIDTH-1:0] r_rx_data;
  logic              w_timer_load;
  logic              w_timer_exp;
  logic              w_tx_take;
  logic              w_rx_hs;
  logic              w_last;

  spi_ss_timer #(.SS_DLY(SS_DLY)) u_ss_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_timer_load),
    .o_expired (w_timer_exp)
  );

  assign w_last = (r_remaining == LEN_W'(1));

  always_comb begin
    w_next       = r_state;
    w_timer_load = 1'b0;
    w_tx_take    = 1'b0;
    w_rx_hs      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            w_next       = ST_SS_SETUP;
            w_timer_load = 1'b1;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_SS_SETUP:  if (w_timer_exp) w_next = ST_LOAD;
      ST_LOAD: begin
        // Abort wins over a pending tx byte so nothing new starts after it.
        if (i_abort) begin
          w_next       = ST_SS_HOLD;
          w_timer_load = 1'b1;
        end else if (i_tx_valid) begin
          w_tx_take = 1'b1;
          w_next    = ST_WAIT_RISE;
        end
      end
      ST_WAIT_RISE: if (i_core_busy) w_next = ST_WAIT_FALL;
      ST_WAIT_FALL: if (!i_core_busy) w_next = ST_READ;
      ST_READ:      w_next = ST_CAPTURE;
      ST_CAPTURE:   w_next = ST_RX_PUSH;
      ST_RX_PUSH: begin
        if (i_rx_ready) begin
          w_rx_hs = 1'b1;
          if (w_last || i_abort) begin
            w_next       = ST_SS_HOLD;
            w_timer_load = 1'b1;
          end else begin
            w_next = ST_LOAD;
          end
        end
      end
      ST_SS_HOLD:   if (w_timer_exp) w_next = ST_DONE;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_ss_n      <= 1'b1;
      r_core_wr   <= 1'b0;
      r_aborted   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_core_din  <= '0;
      r_rx_data   <= '0;
    end else begin
      r_state   <= w_next;
      r_core_wr <= w_tx_take;
      if (r_state == ST_IDLE && i_start) begin
        r_remaining <= i_len;
        r_aborted   <= 1'b0;
        if (i_len != '0) r_ss_n <= 1'b0;
      end
      if (w_tx_take) r_core_din <= i_tx_data;
      if (r_state == ST_CAPTURE) begin
        r_rx_data  <= i_core_dout;
        r_rx_valid <= 1'b1;
      end
      if (w_rx_hs) begin
        r_rx_valid  <= 1'b0;
        r_remaining <= r_remaining - 1'b1;
      end
      // Only flag aborted when bytes were actually left unsent.
      if ((r_state == ST_LOAD && i_abort) || (w_rx_hs && i_abort && !w_last)) r_aborted <= 1'b1;
      if (r_state == ST_SS_HOLD && w_timer_exp) r_ss_n <= 1'b1;
    end
  end

  assign o_tx_ready = w_tx_take;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_aborted  = (r_state == ST_DONE) && r_aborted;
  assign o_ss_n     = r_ss_n;
  assign o_core_wr  = r_core_wr;
  assign o_core_rd  = (r_state == ST_READ);
  assign o_core_cs  = r_core_wr | o_core_rd;
  assign o_core_din = r_core_din;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb/tb_spi_xfer_seq.sv - self-checking bench for spi_xfer_seq with an inverting core model
module tb_spi_xfer_seq;

  localparam int DW  = 8;
  localparam int LW  = 8;
  localparam int SSD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy, done, aborted, ss_n;
  logic          core_cs, core_wr, core_rd;
  logic [DW-1:0] core_din, core_dout;
  logic          core_busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_xfer_seq #(.DWIDTH(DW), .LEN_W(LW), .SS_DLY(SSD)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .i_abort(abort),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_ss_n(ss_n),
    .o_core_cs(core_cs), .o_core_wr(core_wr), .o_core_rd(core_rd),
    .o_core_din(core_din), .i_core_dout(core_dout), .i_core_busy(core_busy)
  );

  // Core model: busy for 4 cycles after a write, returns the inverted byte.
  logic [DW-1:0] core_byte;
  logic [2:0]    core_cnt;
  always @(posedge clk) begin
    if (rst) begin
      core_byte <= '0;
      core_cnt  <= '0;
    end else if (core_cs && core_wr) begin
      core_byte <= ~core_din;
      core_cnt  <= 3'd4;
    end else if (core_cnt != 3'd0) begin
      core_cnt <= core_cnt - 3'd1;
    end
  end
  assign core_busy = (core_cnt != 3'd0);
  assign core_dout = core_byte;

  // TX source: main writes tx_mem/tx_wr, this block owns tx_rd.
  logic [7:0] tx_mem [256];
  logic [7:0] tx_wr = 8'd0;
  logic [7:0] tx_rd = 8'd0;
  logic       tx_pend = 1'b0;
  assign tx_valid = (tx_rd != tx_wr);
  assign tx_data  = tx_mem[tx_rd];

  logic rx_hold = 1'b0;
  assign rx_ready = !rx_hold;

  logic [7:0] rx_mem [256];
  int  rx_n = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  ss_low = 0;
  int  overlap = 0;
  logic last_ab = 1'b0;

  always @(negedge clk) begin
    if (tx_pend) begin
      tx_rd   <= tx_rd + 8'd1;
      tx_pend <= 1'b0;
    end else if (tx_ready) begin
      tx_pend <= 1'b1;
    end
    if (rx_valid && rx_ready) begin
      rx_mem[rx_n[7:0]] <= rx_data;
      rx_n <= rx_n + 1;
    end
    if (core_wr) wr_cnt <= wr_cnt + 1;
    if (core_wr && core_rd) overlap <= overlap + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_ab  <= aborted;
    end
    if (!ss_n) ss_low <= ss_low + 1;
  end

  typedef struct {
    logic [7:0]      len;
    logic [0:4][7:0] tx;
    int              ntx;
    int              abort_at;
    int              exp_wr;
    int              exp_rx;
    logic            exp_ab;
    int              exp_ss;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_wr] = b;
    tx_wr = tx_wr + 8'd1;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < 1000) begin
      tick();
      n++;
    end
    if (done_cnt == base) begin
      total++;
      bad++;
      $display("FAIL %s: no done within 1000 cycles", name);
    end
    repeat (3) tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int b_wr, b_done, b_ss, b_ov, b_rx, n;
    b_wr = wr_cnt; b_done = done_cnt; b_ss = ss_low; b_ov = overlap; b_rx = rx_n;
    for (int i = 0; i < v.ntx; i++) push_tx(v.tx[i]);
    pulse_start(v.len);
    chk_b($sformatf("v%0d_ss_fall", idx), ss_n, 1'b0);
    chk_b($sformatf("v%0d_busy", idx), busy, 1'b1);
    if (v.abort_at != 0) begin
      n = 0;
      while (!((wr_cnt - b_wr) == v.abort_at && core_busy) && n < 500) begin
        tick();
        n++;
      end
      abort = 1'b1;
    end
    wait_done(b_done, $sformatf("v%0d_done", idx));
    abort = 1'b0;
    chk($sformatf("v%0d_done_cnt", idx), done_cnt - b_done, 1);
    chk_b($sformatf("v%0d_aborted", idx), last_ab, v.exp_ab);
    chk($sformatf("v%0d_wr_cnt", idx), wr_cnt - b_wr, v.exp_wr);
    chk($sformatf("v%0d_rx_cnt", idx), rx_n - b_rx, v.exp_rx);
    chk($sformatf("v%0d_ss_low", idx), ss_low - b_ss, v.exp_ss);
    chk($sformatf("v%0d_rd_wr_overlap", idx), overlap - b_ov, 0);
    chk_b($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    chk_b($sformatf("v%0d_idle_ss_n", idx), ss_n, 1'b1);
    for (int i = 0; i < v.exp_rx; i++)
      chk8($sformatf("v%0d_rx%0d", idx, i), rx_mem[(b_rx + i) % 256], ~v.tx[i]);
    tx_wr = tx_rd;
  endtask

  initial begin
    int b_wr, b_done, b_rx, n;
    logic [7:0] d0;

    tbl[0] = '{8'd3, {8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00}, 3, 0, 3, 3, 1'b0, 34};
    tbl[1] = '{8'd1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 0, 1, 1, 1'b0, 14};
    tbl[2] = '{8'd5, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 5, 2, 2, 2, 1'b1, 24};
    tbl[3] = '{8'd4, {8'h80, 8'h01, 8'h7E, 8'hC3, 8'h00}, 4, 0, 4, 4, 1'b0, 44};

    repeat (3) tick();
    chk_b("rst_ss_n", ss_n, 1'b1);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_aborted", aborted, 1'b0);
    chk_b("rst_tx_ready", tx_ready, 1'b0);
    chk_b("rst_rx_valid", rx_valid, 1'b0);
    chk_b("rst_core_cs", core_cs, 1'b0);
    chk_b("rst_core_wr", core_wr, 1'b0);
    chk_b("rst_core_rd", core_rd, 1'b0);
    chk8("rst_core_din", core_din, 8'h00);
    chk8("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(tbl[i], i);

    // len=0: done in the cycle after start, no slave select, no core traffic.
    b_wr = wr_cnt; b_done = done_cnt;
    pulse_start(8'd0);
    chk_b("len0_done", done, 1'b1);
    chk_b("len0_aborted", aborted, 1'b0);
    chk_b("len0_ss_n", ss_n, 1'b1);
    tick();
    chk_b("len0_done_gone", done, 1'b0);
    chk_b("len0_busy_gone", busy, 1'b0);
    chk_b("len0_ss_n_after", ss_n, 1'b1);
    chk("len0_wr_cnt", wr_cnt - b_wr, 0);
    chk("len0_done_cnt", done_cnt - b_done, 1);

    // rx backpressure on byte 1 for 10 cycles.
    b_wr = wr_cnt; b_done = done_cnt; b_rx = rx_n;
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03); push_tx(8'h04);
    rx_hold = 1'b1;
    pulse_start(8'd4);
    n = 0;
    while (!rx_valid && n < 200) begin
      tick();
      n++;
    end
    chk_b("stall_rx_valid_seen", rx_valid, 1'b1);
    d0 = rx_data;
    chk8("stall_first_byte", d0, 8'hFE);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_b($sformatf("stall_valid_c%0d", i), rx_valid, 1'b1);
      chk8($sformatf("stall_data_c%0d", i), rx_data, 8'hFE);
      chk($sformatf("stall_wr_c%0d", i), wr_cnt - b_wr, 1);
    end
    rx_hold = 1'b0;
    wait_done(b_done, "stall_done");
    chk("stall_wr_cnt", wr_cnt - b_wr, 4);
    chk("stall_rx_cnt", rx_n - b_rx, 4);
    chk8("stall_rx3", rx_mem[(b_rx + 3) % 256], 8'hFB);
    tx_wr = tx_rd;

    // Reset in WAIT_FALL of byte 2.
    b_wr = wr_cnt;
    push_tx(8'hAA); push_tx(8'hBB); push_tx(8'hCC);
    pulse_start(8'd3);
    n = 0;
    while (!((wr_cnt - b_wr) == 2 && core_busy) && n < 200) begin
      tick();
      n++;
    end
    chk("rstmid_reached_byte2", wr_cnt - b_wr, 2);
    tick();
    b_done = done_cnt;
    rst = 1'b1;
    tick();
    chk_b("rstmid_ss_n", ss_n, 1'b1);
    chk_b("rstmid_busy", busy, 1'b0);
    chk_b("rstmid_core_cs", core_cs, 1'b0);
    chk_b("rstmid_core_wr", core_wr, 1'b0);
    chk_b("rstmid_core_rd", core_rd, 1'b0);
    chk_b("rstmid_rx_valid", rx_valid, 1'b0);
    chk_b("rstmid_done", done, 1'b0);
    rst = 1'b0;
    tx_wr = tx_rd;
    repeat (5) tick();
    chk("rstmid_no_done", done_cnt - b_done, 0);
    b_wr = wr_cnt; b_rx = rx_n;
    push_tx(8'h5A);
    pulse_start(8'd1);
    wait_done(b_done, "rstmid_restart_done");
    chk("rstmid_restart_done_cnt", done_cnt - b_done, 1);
    chk_b("rstmid_restart_aborted", last_ab, 1'b0);
    chk("rstmid_restart_wr", wr_cnt - b_wr, 1);
    chk8("rstmid_restart_rx", rx_mem[b_rx % 256], 8'hA5);
    tx_wr = tx_rd;

    // start while busy is ignored.
    b_wr = wr_cnt; b_done = done_cnt; b_rx = rx_n;
    push_tx(8'h10); push_tx(8'h20); push_tx(8'h30);
    pulse_start(8'd2);
    repeat (3) tick();
    pulse_start(8'd9);
    wait_done(b_done, "busy_start_done");
    chk("busy_start_wr", wr_cnt - b_wr, 2);
    chk("busy_start_rx", rx_n - b_rx, 2);
    chk("busy_start_done_cnt", done_cnt - b_done, 1);
    chk8("busy_start_rx0", rx_mem[b_rx % 256], 8'hEF);
    chk8("busy_start_rx1", rx_mem[(b_rx + 1) % 256], 8'hDF);
    tx_wr = tx_rd;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
